issue_queue: RTL
================

// Module: issue_queue
// PURPOSE
//   In-order queue that buffers decoded queue_item_t words (50 b) between decode and register read (rrd).
//   Holds each head entry until three conditions are met:
//     - its source/dest registers are free in the scoreboard;
//     - its execution unit (exu_type) is ready;
//     - rrd accepts it.
//   Flushed on branch redirect; exports a saturating stall counter for perf analysis.
// PARAMETERS
//   DEPTH    8    entries; power of 2, >= 2
//   ITEM_W   50   width of packed ctrl_sigs::queue_item_t
//   CNT_W    32   width of stall_cnt
// PORTS
//   clk        in   1                  clock, all state on rising edge
//   rst        in   1                  synchronous, active-high reset
//   enq_valid  in   1                  decode presents an item
//   enq_item   in   ITEM_W             queue_item_t from decode
//   enq_ready  out  1                  queue can accept this cycle
//   flush      in   1                  branch redirect: squash all entries
//   sb_busy    in   32                 scoreboard busy bit per arch reg (bit 0 ignored)
//   exu_ready  in   4                  readiness per exut::exe_unit_type_t index (alu,mul,jmp,mem)
//   iss_valid  out  1                  head item is issuable
//   iss_item   out  ITEM_W             head entry contents (valid only when iss_valid=1)
//   iss_ready  in   1                  rrd accepts
//   count      out  $clog2(DEPTH)+1    occupied entries
//   stall_cnt  out  CNT_W              cycles with a non-empty queue and iss_valid=0
// BEHAVIOUR
//   - Reset, and the cycle after flush:
//       - head_ptr = tail_ptr = 0; count = 0.
//       - Outputs: enq_ready = 1, iss_valid = 0.
//       - stall_cnt = 0 on rst only; flush does not clear it.
//   - Storage: DEPTH x ITEM_W registers. Pointers have width $clog2(DEPTH) and wrap modulo DEPTH.
//     count distinguishes full from empty.
//   - enq_fire = enq_valid & enq_ready.
//       - enq_ready = (count != DEPTH) & ~flush. It is not combinationally dependent on iss_ready,
//         so a full queue refuses enq even in a cycle where it dequeues.
//       - On enq_fire, the item is written at tail_ptr and tail_ptr advances.
//   - Head: iss_item = mem[head_ptr], combinational from storage.
//       - An item enqueued at cycle N is first presentable at cycle N+1.
//       - There is no empty-queue bypass.
//   - Hazard, evaluated on head fields:
//       - (has_rs1 & rs1!=0 & sb_busy[rs1])
//       - | (has_rs2 & rs2!=0 & sb_busy[rs2])
//       - | (has_rd & rd!=0 & sb_busy[rd])   (WAW)
//   - iss_valid = (count!=0) & ~hazard & exu_ready[exu_type] & ~flush.
//       - It is allowed to depend combinationally on sb_busy and exu_ready, but never on iss_ready.
//       - Once asserted, it may drop if sb_busy or exu_ready change; rrd must not assume stickiness.
//   - iss_fire = iss_valid & iss_ready: head_ptr advances next edge.
//   - Simultaneous enq_fire & iss_fire: both take effect; count unchanged.
//     When count==1 the old head leaves and the new item becomes the head.
//   - flush priority: flush > enq/iss. In the flush cycle no enq is accepted and no issue fires;
//     the queue is empty on the next cycle.
//   - rst has priority over flush. rst asserted mid-stream discards all entries, same as flush.
//   - stall_cnt increments when (count!=0) & ~iss_valid & ~flush, and saturates at all-ones.
//   - Item fields pass through unmodified, including taken, shadowed and packed_imm; no decoding here.
//   - Assertions (sim only): no enq_fire when count==DEPTH; no iss_fire when count==0.
// TESTING
//   1. Reset, enqueue 3 ALU items (rs1=1, rs2=2, rd=3) with sb_busy=0, exu_ready=4'b1111, iss_ready=1
//      -> iss_valid rises 1 cycle after the first enq; 3 consecutive issues in order; count returns to 0.
//   2. Fill to DEPTH=8 with iss_ready=0 -> enq_ready=0 at count=8. Assert iss_ready for 1 cycle
//      -> count=7 next cycle, enq_ready=1; the 9th item is accepted afterwards, wrapping to slot 0.
//   3. Head has rs2=5, sb_busy[5]=1 for 4 cycles -> iss_valid=0 for 4 cycles, stall_cnt=4.
//      Clear the bit -> issues next cycle. Head with rs1=0 and sb_busy[0]=1 -> no stall.
//   4. Head exu_type=mem, exu_ready=4'b0111 -> held; set bit 3 -> iss_valid=1 that cycle.
//   5. count=5, assert flush together with enq_valid=1 and iss_ready=1 -> no issue or enq that cycle;
//      next cycle count=0 and iss_valid=0; stall_cnt retained.
//   6. count=1 with simultaneous enq and issue -> count stays 1; the new item appears at iss_item next cycle.
//      rst mid-stream -> count=0 and stall_cnt=0.

Source files
------------

// File: rtl/issue_queue.sv
// In-order issue queue between decode and register read.
// Holds the head until its scoreboard registers are free, its unit is ready and rrd accepts.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   enq_valid/item/rdy  decode-side handshake (queue_item_t words)
//   flush               branch redirect, squashes every entry
//   sb_busy             scoreboard busy bit per arch register (bit 0 ignored)
//   exu_ready           readiness per execution unit (alu,mul,jmp,mem)
//   iss_valid/item/rdy  rrd-side handshake; iss_item is the head entry
//   count               occupied entries
//   stall_cnt           saturating count of non-empty cycles with no issuable head

package ctrl_sigs;

    typedef enum logic [1:0] {
        EXU_ALU = 2'd0,
        EXU_MUL = 2'd1,
        EXU_JMP = 2'd2,
        EXU_MEM = 2'd3
    } exe_unit_type_t;

    typedef struct packed {
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
        logic           has_rs1;
        logic           has_rs2;
        logic           has_rd;
        exe_unit_type_t exu_type;
        logic           taken;
        logic           shadowed;
        logic [27:0]    packed_imm;
    } queue_item_t;

endpackage

module issue_queue
    import ctrl_sigs::*;
#(
    parameter int DEPTH  = 8,
    parameter int ITEM_W = 50,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enq_valid,
    input  logic [ITEM_W-1:0]        enq_item,
    output logic                     enq_ready,
    input  logic                     flush,
    input  logic [31:0]              sb_busy,
    input  logic [3:0]               exu_ready,
    output logic                     iss_valid,
    output logic [ITEM_W-1:0]        iss_item,
    input  logic                     iss_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         stall_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ITEM_W-1:0] mem_q [DEPTH];
    logic [ITEM_W-1:0] mem_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    queue_item_t head_item;
    logic        hazard;
    logic        enq_fire;
    logic        iss_fire;
    logic        stall_inc;

    assign head_item = queue_item_t'(mem_q[head_q]);
    assign iss_item  = mem_q[head_q];
    assign count     = count_q;
    assign stall_cnt = stall_q;

    // Full queue refuses enq even if the head leaves this cycle,
    // keeping enq_ready independent of iss_ready.
    assign enq_ready = (count_q != CW'(DEPTH)) && !flush;
    assign enq_fire  = enq_valid && enq_ready;

    // Register x0 never blocks; rd check covers WAW.
    always_comb begin
        hazard = 1'b0;
        if (head_item.has_rs1 && head_item.rs1 != 5'd0 && sb_busy[head_item.rs1])
            hazard = 1'b1;
        if (head_item.has_rs2 && head_item.rs2 != 5'd0 && sb_busy[head_item.rs2])
            hazard = 1'b1;
        if (head_item.has_rd && head_item.rd != 5'd0 && sb_busy[head_item.rd])
            hazard = 1'b1;
    end

    assign iss_valid = (count_q != '0) && !hazard
                     && exu_ready[head_item.exu_type] && !flush;
    assign iss_fire  = iss_valid && iss_ready;
    assign stall_inc = (count_q != '0) && !iss_valid && !flush;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        stall_d = stall_q;

        if (enq_fire) begin
            mem_d[tail_q] = enq_item;
            tail_d        = tail_q + 1'b1;
        end

        if (iss_fire)
            head_d = head_q + 1'b1;

        unique case ({enq_fire, iss_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (stall_inc && stall_q != '1)
            stall_d = stall_q + 1'b1;

        // enq/iss are already gated by flush; just empty the queue.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            stall_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            stall_q <= stall_d;
        end
    end

    // Payload needs no reset: count gates everything read from it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_fire && count_q == CW'(DEPTH)));
            assert (!(iss_fire && count_q == '0));
        end
    end
`endif

endmodule
